// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice, LSB first.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output o_overflow.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             o_overflow,
`endif
  output logic             o_carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             r_ovf;
`endif

  logic w_accept;
  logic w_last;
  logic w_s;
  logic w_c_next;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_next = majority(r_a[0], r_b[0], r_c);

  // Operand shift registers carry no state that matters outside SHIFT, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= i_a;
      r_b <= i_b ^ {WIDTH{i_sub}};
    end else if (r_state == S_SHIFT) begin
      r_a <= {1'b0, r_a[WIDTH-1:1]};
      r_b <= {1'b0, r_b[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_c     <= i_sub;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_c   <= w_c_next;
          r_res <= {w_s, r_res[WIDTH-1:1]};
          if (w_last) begin
            // Carry into the MSB is r_c; carry out is w_c_next.
            r_cout  <= w_c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf   <= r_c ^ w_c_next;
`endif
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_res;
  assign o_carry_out = r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign o_overflow  = r_ovf;
`endif

endmodule
